// File: rtl/button_conditioner.sv
// Conditions the five Nexys pushbuttons: synchronise, debounce, and emit level,
// press/release pulses, optional auto-repeat and a sticky press flag per button.

module button_conditioner_ch #(
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CYCLES    = 1000000,
    parameter int REPEAT_DELAY = 40000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter bit REPEAT_ON    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_sticky_clr,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat,
    output logic o_sticky
);
    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE) + 1;
    localparam logic [CW-1:0] DB_MAX    = CW'(DB_CYCLES);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [RW-1:0]          r_rep;
    logic [RW-1:0]          w_rep_nxt;
    logic [RW-1:0]          w_rep_inc;
    logic [RW-1:0]          w_rep_step;
    logic                   w_s;
    logic                   w_press;
    logic                   w_release;
    logic                   w_repeat;
    logic                   w_level;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rep_inc = r_rep + RW'(1);
    // Reload to the first-repeat point instead of wrapping, so the phase is kept forever.
    assign w_rep_step = (w_rep_inc == REP_WRAP) ? REP_FIRST : w_rep_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rep     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_repeat  <= 1'b0;
            o_sticky  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rep     <= w_rep_nxt;
            o_level   <= w_level;
            o_press   <= w_press;
            o_release <= w_release;
            o_repeat  <= w_repeat;
            // A press in the same cycle as a clear wins.
            o_sticky  <= w_press | (o_sticky & ~i_sticky_clr);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (r_cnt == DB_MAX) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_rep_nxt   = '0;
                end else if (w_s) begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            HELD: begin
                w_rep_nxt = w_rep_step;
                if (!w_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                w_rep_nxt = w_rep_step;
                if (r_cnt == DB_MAX) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_s) begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end else begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_press   = (r_state == PRESS_WAIT) && (r_cnt == DB_MAX);
        w_release = (r_state == RELEASE_WAIT) && (r_cnt == DB_MAX);
        w_level   = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
        // Repeats fire only while settled in HELD, never during a release debounce.
        w_repeat  = REPEAT_ON && (r_state == HELD) && w_s &&
                    ((w_rep_inc == REP_FIRST) || (w_rep_inc == REP_WRAP));
    end
endmodule

module button_conditioner #(
    parameter int         SYNC_STAGES  = 2,
    parameter int         DB_CYCLES    = 1000000,
    parameter int         REPEAT_DELAY = 40000000,
    parameter int         REPEAT_RATE  = 10000000,
    parameter logic [4:0] REPEAT_EN    = 5'b00110
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_btn_raw,
    input  logic [4:0] i_sticky_clr,
    output logic [4:0] o_btn_level,
    output logic [4:0] o_btn_press,
    output logic [4:0] o_btn_release,
    output logic [4:0] o_btn_repeat,
    output logic [4:0] o_btn_sticky
);
    for (genvar gi = 0; gi < 5; gi++) begin : g_ch
        button_conditioner_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .REPEAT_ON   (REPEAT_EN[gi])
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_raw       (i_btn_raw[gi]),
            .i_sticky_clr(i_sticky_clr[gi]),
            .o_level     (o_btn_level[gi]),
            .o_press     (o_btn_press[gi]),
            .o_release   (o_btn_release[gi]),
            .o_repeat    (o_btn_repeat[gi]),
            .o_sticky    (o_btn_sticky[gi])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random buttons, all checked
// against an event-level model of debounce, repeat timing and the sticky flag.

module tb_button_conditioner;
    localparam int         SYNC   = 2;
    localparam int         DB     = 4;
    localparam int         DLY    = 10;
    localparam int         RATE   = 3;
    localparam logic [4:0] REP_EN = 5'b00110;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic [4:0] sticky_clr;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat, btn_sticky;

    int checks;
    int failures;

    // Model state: raw history stands in for the synchroniser delay.
    logic [4:0] m_hist[$];
    logic [4:0] m_level, m_press, m_release, m_repeat, m_sticky;
    int         m_run[5];
    int         m_t[5];
    bit         m_pend[5];

    button_conditioner #(
        .SYNC_STAGES (SYNC),
        .DB_CYCLES   (DB),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE),
        .REPEAT_EN   (REP_EN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_btn_raw    (btn_raw),
        .i_sticky_clr (sticky_clr),
        .o_btn_level  (btn_level),
        .o_btn_press  (btn_press),
        .o_btn_release(btn_release),
        .o_btn_repeat (btn_repeat),
        .o_btn_sticky (btn_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [24:0] dut_vec();
        return {btn_level, btn_press, btn_release, btn_repeat, btn_sticky};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {m_level, m_press, m_release, m_repeat, m_sticky};
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(5'b0);
        m_level = '0; m_press = '0; m_release = '0; m_repeat = '0; m_sticky = '0;
        for (int c = 0; c < 5; c++) begin
            m_run[c] = 0; m_t[c] = 0; m_pend[c] = 1'b0;
        end
    endtask

    // A level change is accepted on the edge after DB consecutive differing samples;
    // repeats land at DLY, DLY+RATE, ... edges after the press while settled and held.
    task automatic model_edge();
        logic [4:0] s;
        s = m_hist.pop_front();
        m_hist.push_back(btn_raw);
        m_press = '0; m_release = '0; m_repeat = '0;
        for (int c = 0; c < 5; c++) begin
            if (m_pend[c]) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) begin
                    m_press[c] = 1'b1;
                    m_t[c] = 0;
                end else begin
                    m_release[c] = 1'b1;
                end
                m_run[c] = 0;
                m_pend[c] = 1'b0;
            end else begin
                if (m_level[c]) begin
                    m_t[c]++;
                    if (REP_EN[c] && m_run[c] == 0 && s[c] && m_t[c] >= DLY &&
                        (m_t[c] - DLY) % RATE == 0)
                        m_repeat[c] = 1'b1;
                end
                if (s[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) m_pend[c] = 1'b1;
                end else begin
                    m_run[c] = 0;
                end
            end
            m_sticky[c] = m_press[c] | (m_sticky[c] & ~sticky_clr[c]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_raw = '0; sticky_clr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec() !== 25'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", dut_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        int press_e, level_e, rel_e;
        int reps[$];
        press_e = -1; level_e = -1; rel_e = -1;
        for (int k = 0; k < 36; k++) begin
            btn_raw[2] = (k < 25);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL clean_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (btn_press[2] && press_e < 0) press_e = k;
            if (btn_level[2] && level_e < 0) level_e = k;
            if (btn_repeat[2] && k < 25) reps.push_back(k);
            if (btn_release[2] && rel_e < 0) rel_e = k;
        end
        checks++;
        if (press_e != 6 || level_e != 6) begin
            failures++;
            $display("FAIL clean_press_edge got press=%0d level=%0d exp=6", press_e, level_e);
        end
        checks++;
        if (reps.size() != 3 || reps[0] != 16 || reps[1] != 19 || reps[2] != 22) begin
            failures++;
            $display("FAIL clean_repeat_edges got count=%0d exp 16,19,22", reps.size());
        end
        checks++;
        if (rel_e != 31 || btn_level[2] !== 1'b0) begin
            failures++;
            $display("FAIL clean_release_edge got=%0d level=%b exp=31 level=0", rel_e, btn_level[2]);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        int npress;
        seen = 1'b0; npress = 0;
        for (int k = 0; k < 14; k++) begin
            btn_raw[4] = (k < 3);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL glitch3_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (btn_level[4] || btn_press[4] || btn_sticky[4]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL glitch3_rejected got=accepted exp=rejected");
        end
        for (int k = 0; k < 16; k++) begin
            btn_raw[4] = (k < 4);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL glitch4_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (btn_press[4]) npress++;
        end
        checks++;
        if (npress != 1) begin
            failures++;
            $display("FAIL glitch4_accepted got presses=%0d exp=1", npress);
        end
    endtask

    task automatic test_release_bounce();
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < 36; k++) begin
            btn_raw[1] = (k < 10) || (k >= 12 && k < 25);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bounce_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k >= 7 && k < 30 && (btn_release[1] || btn_press[1] || !btn_level[1])) bad = 1'b1;
        end
        checks++;
        if (bad || btn_level[1] !== 1'b0) begin
            failures++;
            $display("FAIL bounce_no_release got bad=%b level=%b exp bad=0 level=0", bad, btn_level[1]);
        end
    endtask

    task automatic test_sticky();
        for (int k = 0; k < 20; k++) begin
            btn_raw[3] = (k < 8);
            tick();
        end
        checks++;
        if (btn_sticky[3] !== 1'b1 || btn_level[3] !== 1'b0 || exp_vec() !== dut_vec()) begin
            failures++;
            $display("FAIL sticky_hold got=%b exp=1", btn_sticky[3]);
        end
        sticky_clr[3] = 1'b1;
        tick();
        sticky_clr[3] = 1'b0;
        checks++;
        if (btn_sticky[3] !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear got=%b exp=0", btn_sticky[3]);
        end
        for (int k = 0; k < 20; k++) begin
            btn_raw[3]    = (k < 10);
            sticky_clr[3] = (k >= 4 && k <= 7);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL sticky_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k == 6) begin
                checks++;
                if (btn_sticky[3] !== 1'b1) begin
                    failures++;
                    $display("FAIL sticky_set_wins got=%b exp=1", btn_sticky[3]);
                end
            end
            if (k == 7) begin
                checks++;
                if (btn_sticky[3] !== 1'b0) begin
                    failures++;
                    $display("FAIL sticky_clear_after_set got=%b exp=0", btn_sticky[3]);
                end
            end
        end
        sticky_clr[3] = 1'b0;
    endtask

    task automatic test_simultaneous();
        int nrep;
        nrep = 0;
        for (int k = 0; k < 46; k++) begin
            btn_raw[4] = (k < 36);
            btn_raw[0] = (k < 36);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL simul_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (k == 6) begin
                checks++;
                if (btn_press !== 5'b10001) begin
                    failures++;
                    $display("FAIL simul_press got=%b exp=10001", btn_press);
                end
            end
            if (btn_repeat[4] || btn_repeat[0]) nrep++;
        end
        checks++;
        if (nrep != 0) begin
            failures++;
            $display("FAIL simul_no_repeat got=%0d exp=0", nrep);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < 5; c++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[c] = ~btn_raw[c];
                sticky_clr[c] = ($urandom_range(0, 7) == 0);
            end
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
        btn_raw = '0;
        sticky_clr = '0;
        repeat (20) tick();
    endtask

    task automatic test_async_reset();
        int press_e;
        press_e = -1;
        btn_raw[2] = 1'b1;
        repeat (10) tick();
        checks++;
        if (btn_level[2] !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_held got=%b exp=1", btn_level[2]);
        end
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 25'b0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h exp=0", dut_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL async_model edge=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
            end
            if (btn_press[2] && press_e < 0) press_e = k;
        end
        checks++;
        if (press_e != 6) begin
            failures++;
            $display("FAIL async_press_edge got=%0d exp=6", press_e);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_sticky();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
